ufm_writer: RTL and testbench
=============================

Name: ufm_writer

Overview:
- Wishbone initiator that programs one 16-byte UFM page, optionally erasing the whole UFM first.
- Drives the MachXO2 EFB configuration port (CFGCR/CFGTXDR/CFGSR/CFGRXDR).
- Companion to the UFM read path. Shares the same EFB WB master signals through the top-level arbiter.
- Page data is pulled byte-serially from an upstream source (page buffer or UART loader).

Parameters:
- POLL_LIMIT, 16'd65535: max status polls per busy-wait before declaring timeout.
- EFB_BASE, 8'h70: WB address of CFGCR; TXDR=+1, SR=+2, RXDR=+3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse, accepted only when busy=0
- erase  in  1  sampled with start; 1 = erase UFM before programming
- page_addr  in  11  UFM page index, sampled with start
- data_in  in  8  next page byte, valid the cycle after data_req
- data_req  out  1  one-cycle pulse requesting the next byte (16 per page)
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse on success
- error  out  1  one-cycle pulse on fail-flag or poll timeout
- cyc, stb, we  out  1  WB master controls
- adr  out  8  WB address
- data_o  out  8  WB write data
- data_i  in  8  WB read data
- wb_ack  in  1  WB acknowledge

Behaviour:
- Reset: cyc=stb=we=0, adr=0, data_o=0, data_req=busy=done=error=0, FSM=IDLE. Reset mid-operation aborts immediately; no closing frame is sent (EFB recovers on the next enable).
- WB cycle: cyc=stb asserted with adr/we/data_o stable until the cycle where wb_ack=1. Deassert the next cycle. At least one idle cycle between transactions. No timeout on ack.
- Frame: write CFGCR=0x80, then N bytes to TXDR (or RX bytes read from RXDR), then write CFGCR=0x00.
- Command sequence (bytes MSB-first):
  - 1 ENABLE: frame 74 08 00 00; then POLL.
  - 2 ERASE (only if erase latched): frame CB 00 00 00; then POLL.
  - 3 SETADDR: frame B4 00 00 00 40 00 {5'b0,addr[10:8]} addr[7:0].
  - 4 PROG: frame C9 00 00 01 + 16 data bytes; then POLL.
  - 5 DISABLE: frame 26 00 00.
  - 6 BYPASS: frame FF FF FF FF.
  - 7 done.
- Payload: data_req pulses once per payload byte, the cycle before that TXDR write is launched. data_in is captured the following cycle. Exactly 16 pulses per operation; none when an error occurs before PROG.
- POLL: frame 3C 00 00 00, then 4 RXDR reads (status bits 31..0, MSB byte first).
  - Busy = bit 12 (byte 2, bit 4); fail = bit 13 (byte 2, bit 5).
  - busy=1 -> repeat POLL, increment poll counter.
  - fail=1, or counter reaches POLL_LIMIT -> ERR. Counter clears on each new POLL phase.
- ERR: send DISABLE and BYPASS frames, pulse error, return to IDLE. done and error are never asserted together.
- FSM states: IDLE, OPEN, TX, RX, CLOSE, POLL_EVAL, ERR, FIN. A step/byte-index counter selects the command byte from a constant ROM.
- start while busy=1 is ignored. Inputs are only sampled at the accepted start.
- busy drops in the same cycle done/error pulses.

Test Plan:
- erase=0, page_addr=11'h123, EFB model never busy -> WB write trace exactly matches ENABLE/POLL/SETADDR (…40 00 01 23)/PROG/POLL/DISABLE/BYPASS; 16 data_req pulses; done pulses once; cyc low after.
- erase=1 -> CB 00 00 00 frame plus POLL inserted after ENABLE's POLL; otherwise same trace as above.
- Model reports busy for 5 polls after PROG -> 6 status frames issued, then done; no error.
- Model reports fail bit after ERASE -> DISABLE+BYPASS sent, error pulses once, zero data_req pulses, busy=0.
- POLL_LIMIT=4, model always busy -> exactly 4 polls, then error; model delays wb_ack 0–7 random cycles -> stb/adr/data_o held stable until ack (assertion).
- rst asserted mid-PROG (byte 7) -> next cycle all outputs at reset values. Subsequent start completes a normal trace.

Source files
------------

// File: rtl/ufm_writer.sv
// Wishbone initiator that programs one 16-byte MachXO2 UFM page through the EFB config port, optionally erasing first.
// One WB transfer in flight; each transfer is held until wb_ack, with an idle cycle before the next one.
module ufm_writer #(
   parameter logic [15:0] POLL_LIMIT = 16'd65535,
   parameter logic [7:0]  EFB_BASE   = 8'h70
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        erase,
   input  logic [10:0] page_addr,
   input  logic [7:0]  data_in,
   output logic        data_req,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cyc,
   output logic        stb,
   output logic        we,
   output logic [7:0]  adr,
   output logic [7:0]  data_o,
   input  logic [7:0]  data_i,
   input  logic        wb_ack
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_OPEN  = 3'd1;
   localparam logic [2:0] S_TX    = 3'd2;
   localparam logic [2:0] S_RX    = 3'd3;
   localparam logic [2:0] S_CLOSE = 3'd4;
   localparam logic [2:0] S_EVAL  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;
   localparam logic [2:0] S_FIN   = 3'd7;

   localparam logic [3:0] ST_ENABLE  = 4'd0;
   localparam logic [3:0] ST_POLL_EN = 4'd1;
   localparam logic [3:0] ST_ERASE   = 4'd2;
   localparam logic [3:0] ST_POLL_ER = 4'd3;
   localparam logic [3:0] ST_SETADDR = 4'd4;
   localparam logic [3:0] ST_PROG    = 4'd5;
   localparam logic [3:0] ST_POLL_PG = 4'd6;
   localparam logic [3:0] ST_DISABLE = 4'd7;
   localparam logic [3:0] ST_BYPASS  = 4'd8;

   logic [2:0]  state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [4:0]  idx_q, idx_d;
   logic        erase_q, erase_d;
   logic [10:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [15:0] poll_cnt_q, poll_cnt_d;
   logic [7:0]  stat_q, stat_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [7:0]  adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic        pend_q, pend_d;
   logic        data_req_q, data_req_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        payload;

   function automatic logic is_poll(input logic [3:0] s);
      return (s == ST_POLL_EN) || (s == ST_POLL_ER) || (s == ST_POLL_PG);
   endfunction

   // Index of the last TXDR byte in each command's frame (PROG includes its 16 data bytes).
   function automatic logic [4:0] frame_last(input logic [3:0] s);
      case (s)
         ST_SETADDR: return 5'd7;
         ST_PROG:    return 5'd19;
         ST_DISABLE: return 5'd2;
         default:    return 5'd3;
      endcase
   endfunction

   function automatic logic [7:0] cmd_byte(input logic [3:0] s, input logic [4:0] i, input logic [10:0] a);
      logic [63:0] w;
      case (s)
         ST_ENABLE:  w = {32'h7408_0000, 32'h0};
         ST_ERASE:   w = {32'hCB00_0000, 32'h0};
         ST_SETADDR: w = {32'hB400_0000, 16'h4000, 5'b0, a};
         ST_PROG:    w = {32'hC900_0001, 32'h0};
         ST_DISABLE: w = {24'h26_0000, 40'h0};
         ST_BYPASS:  w = {32'hFFFF_FFFF, 32'h0};
         default:    w = {32'h3C00_0000, 32'h0};
      endcase
      w = w << {i[2:0], 3'b000};
      return w[63:56];
   endfunction

   assign payload = (step_q == ST_PROG) && (idx_q >= 5'd4);

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      idx_d      = idx_q;
      erase_d    = erase_q;
      addr_d     = addr_q;
      err_d      = err_q;
      poll_cnt_d = poll_cnt_q;
      stat_d     = stat_q;
      cyc_d      = cyc_q;
      we_d       = we_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      data_req_d = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d     = 1'b1;
               erase_d    = erase;
               addr_d     = page_addr;
               step_d     = ST_ENABLE;
               err_d      = 1'b0;
               poll_cnt_d = 16'd0;
               state_d    = S_OPEN;
            end
         end
         S_OPEN: begin
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               adr_d = EFB_BASE;
               dat_d = 8'h80;
            end else if (wb_ack) begin
               cyc_d   = 1'b0;
               idx_d   = 5'd0;
               state_d = S_TX;
            end
         end
         S_TX: begin
            if (cyc_q) begin
               if (wb_ack) begin
                  cyc_d = 1'b0;
                  if (idx_q == frame_last(step_q)) begin
                     idx_d   = 5'd0;
                     state_d = is_poll(step_q) ? S_RX : S_CLOSE;
                  end else begin
                     idx_d = idx_q + 5'd1;
                  end
               end
            end else if (payload) begin
               // Request, wait for the byte to become valid, then launch with it.
               if (pend_q) begin
                  pend_d = 1'b0;
                  cyc_d  = 1'b1;
                  we_d   = 1'b1;
                  adr_d  = EFB_BASE + 8'd1;
                  dat_d  = data_in;
               end else if (data_req_q) begin
                  pend_d = 1'b1;
               end else begin
                  data_req_d = 1'b1;
               end
            end else begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               adr_d = EFB_BASE + 8'd1;
               dat_d = cmd_byte(step_q, idx_q, addr_q);
            end
         end
         S_RX: begin
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b0;
               adr_d = EFB_BASE + 8'd3;
               dat_d = 8'h00;
            end else if (wb_ack) begin
               cyc_d = 1'b0;
               if (idx_q == 5'd2) stat_d = data_i;
               if (idx_q == 5'd3) begin
                  idx_d   = 5'd0;
                  state_d = S_CLOSE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_CLOSE: begin
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               adr_d = EFB_BASE;
               dat_d = 8'h00;
            end else if (wb_ack) begin
               cyc_d = 1'b0;
               if (is_poll(step_q)) begin
                  state_d = S_EVAL;
               end else if (step_q == ST_BYPASS) begin
                  state_d = S_FIN;
               end else begin
                  step_d  = step_q + 4'd1;
                  state_d = S_OPEN;
               end
            end
         end
         S_EVAL: begin
            // Status byte 2: bit 5 = fail, bit 4 = busy.
            if (stat_q[5]) begin
               state_d = S_ERR;
            end else if (stat_q[4]) begin
               poll_cnt_d = poll_cnt_q + 16'd1;
               state_d    = ((poll_cnt_q + 16'd1) >= POLL_LIMIT) ? S_ERR : S_OPEN;
            end else begin
               poll_cnt_d = 16'd0;
               step_d     = (step_q == ST_POLL_EN && !erase_q) ? ST_SETADDR : step_q + 4'd1;
               state_d    = S_OPEN;
            end
         end
         S_ERR: begin
            err_d      = 1'b1;
            poll_cnt_d = 16'd0;
            step_d     = ST_DISABLE;
            state_d    = S_OPEN;
         end
         S_FIN: begin
            busy_d  = 1'b0;
            done_d  = !err_q;
            error_d = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_q     <= ST_ENABLE;
         idx_q      <= 5'd0;
         erase_q    <= 1'b0;
         addr_q     <= 11'd0;
         err_q      <= 1'b0;
         poll_cnt_q <= 16'd0;
         stat_q     <= 8'd0;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= 8'd0;
         dat_q      <= 8'd0;
         pend_q     <= 1'b0;
         data_req_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         idx_q      <= idx_d;
         erase_q    <= erase_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         poll_cnt_q <= poll_cnt_d;
         stat_q     <= stat_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         pend_q     <= pend_d;
         data_req_q <= data_req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign cyc      = cyc_q;
   assign stb      = cyc_q;
   assign we       = we_q;
   assign adr      = adr_q;
   assign data_o   = dat_q;
   assign data_req = data_req_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_ufm_writer.sv
// Bench for ufm_writer: EFB/WB responder model, page-data source, trace comparison against built command frames.
module tb_ufm_writer;
   localparam logic [15:0] LIMIT = 16'd6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        erase = 1'b0;
   logic [10:0] page_addr = 11'd0;
   logic [7:0]  data_in = 8'hEE;
   logic [7:0]  data_i = 8'h00;
   logic        wb_ack = 1'b0;
   logic        data_req, busy, done, error, cyc, stb, we;
   logic [7:0]  adr, data_o;

   ufm_writer #(.POLL_LIMIT(LIMIT), .EFB_BASE(8'h70)) dut (
      .clk(clk), .rst(rst), .start(start), .erase(erase), .page_addr(page_addr),
      .data_in(data_in), .data_req(data_req), .busy(busy), .done(done), .error(error),
      .cyc(cyc), .stb(stb), .we(we), .adr(adr), .data_o(data_o), .data_i(data_i), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          erase;
      logic [10:0] addr;
      int          busy_op;
      int          busy_n;
      int          fail_op;
      bit          delay;
      bit          exp_done;
      int          exp_reqs;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cfg_busy_op = -1;
   int cfg_busy_n = 0;
   int cfg_fail_op = -1;
   bit cfg_delay = 1'b0;
   int req_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, viol_cnt = 0;
   int wait_cnt = 0, busy_left = 0, rd_idx = 0;
   bit fail_now = 1'b0, first_tx = 1'b0;
   logic [16:0] trace[$];
   logic [16:0] exp_q[$];
   vec_t tbl[7];

   function automatic logic [7:0] pay(input int n);
      return 8'(n * 37 + 11);
   endfunction

   // EFB responder: random ack delay, RXDR status per poll, page-byte source.
   always @(posedge clk) begin
      if (rst) begin
         wb_ack   <= 1'b0;
         wait_cnt <= 0;
         data_in  <= 8'hEE;
         rd_idx   <= 0;
         first_tx <= 1'b0;
      end else begin
         data_in <= data_req ? pay(req_cnt) : 8'hEE;
         if (data_req) req_cnt <= req_cnt + 1;
         if (wb_ack) begin
            wb_ack <= 1'b0;
         end else if (cyc && stb) begin
            if (wait_cnt == 0) begin
               wb_ack <= 1'b1;
               trace.push_back({we, adr, we ? data_o : 8'h00});
               if (we && adr == 8'h70 && data_o == 8'h80) begin
                  first_tx <= 1'b1;
               end else if (we && adr == 8'h71 && first_tx) begin
                  first_tx <= 1'b0;
                  if (data_o != 8'h3C) begin
                     busy_left <= (int'(data_o) == cfg_busy_op) ? cfg_busy_n : 0;
                     fail_now  <= (int'(data_o) == cfg_fail_op);
                  end
               end
               if (!we && adr == 8'h73) begin
                  if (rd_idx == 2) data_i <= {2'b11, fail_now, (busy_left > 0), 4'hF};
                  else data_i <= 8'h30;
                  if (rd_idx == 3) begin
                     rd_idx <= 0;
                     if (busy_left > 0) busy_left <= busy_left - 1;
                  end else begin
                     rd_idx <= rd_idx + 1;
                  end
               end
            end else begin
               wait_cnt <= wait_cnt - 1;
            end
         end else begin
            wait_cnt <= cfg_delay ? int'($urandom_range(0, 7)) : 0;
         end
      end
   end

   // Bus-protocol and pulse monitor, sampled mid-cycle.
   logic p_stb = 1'b0, p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rst = 1'b1;
   logic [7:0] p_adr = 8'h00, p_dat = 8'h00;
   always @(negedge clk) begin
      if (!rst && !p_rst) begin
         if (p_stb && !p_ack && (!stb || adr !== p_adr || data_o !== p_dat || we !== p_we))
            viol_cnt++;
         if (p_cyc && p_ack && cyc) viol_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) err_cnt++;
      if (done === 1'b1 && error === 1'b1) both_cnt++;
      p_stb = stb; p_cyc = cyc; p_ack = wb_ack; p_we = we; p_adr = adr; p_dat = data_o; p_rst = rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic add_w(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({1'b1, a, d});
   endtask

   task automatic add_frame(input logic [63:0] w, input int n);
      logic [63:0] t;
      add_w(8'h70, 8'h80);
      for (int i = 0; i < n; i++) begin
         t = w << (8 * i);
         add_w(8'h71, t[63:56]);
      end
      add_w(8'h70, 8'h00);
   endtask

   task automatic add_poll();
      add_frame({32'h3C00_0000, 32'h0}, 4);
      void'(exp_q.pop_back());
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h73, 8'h00});
      add_w(8'h70, 8'h00);
   endtask

   task automatic do_polls(input int op, input vec_t v, output bit fail);
      int n;
      n = (op == v.busy_op) ? v.busy_n : 0;
      fail = 1'b0;
      for (int k = 0; k < 100; k++) begin
         add_poll();
         if (op == v.fail_op) begin fail = 1'b1; break; end
         if (k >= n) break;
         if (k + 1 >= int'(LIMIT)) begin fail = 1'b1; break; end
      end
   endtask

   task automatic build_exp(input vec_t v, input int base);
      bit fail;
      exp_q.delete();
      add_frame({32'h7408_0000, 32'h0}, 4);
      do_polls(8'h74, v, fail);
      if (!fail && v.erase) begin
         add_frame({32'hCB00_0000, 32'h0}, 4);
         do_polls(8'hCB, v, fail);
      end
      if (!fail) begin
         add_frame({32'hB400_0000, 16'h4000, 5'b0, v.addr}, 8);
         add_w(8'h70, 8'h80);
         add_w(8'h71, 8'hC9); add_w(8'h71, 8'h00); add_w(8'h71, 8'h00); add_w(8'h71, 8'h01);
         for (int k = 0; k < 16; k++) add_w(8'h71, pay(base + k));
         add_w(8'h70, 8'h00);
         do_polls(8'hC9, v, fail);
      end
      add_frame({24'h26_0000, 40'h0}, 3);
      add_frame({32'hFFFF_FFFF, 32'h0}, 4);
   endtask

   task automatic wait_end(input int d0, input int e0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (done_cnt != d0 || err_cnt != e0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int rb, db, eb, bb, vb, tb0, n_act, mism, bad_i;
      bit ok;
      logic [16:0] got_b, want_b;
      cfg_busy_op = v.busy_op; cfg_busy_n = v.busy_n; cfg_fail_op = v.fail_op; cfg_delay = v.delay;
      @(negedge clk);
      rb = req_cnt; db = done_cnt; eb = err_cnt; bb = both_cnt; vb = viol_cnt; tb0 = trace.size();
      build_exp(v, rb);
      start = 1'b1; erase = v.erase; page_addr = v.addr;
      @(negedge clk);
      start = 1'b0; erase = !v.erase; page_addr = ~v.addr;
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end(db, eb, ok);
      chk($sformatf("v%0d completes", id), 32'(ok), 32'd1);
      if (!ok) begin rst = 1'b1; @(negedge clk); rst = 1'b0; end
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d done pulses", id), done_cnt - db, 32'(v.exp_done));
      chk($sformatf("v%0d error pulses", id), err_cnt - eb, 32'(!v.exp_done));
      chk($sformatf("v%0d data_req pulses", id), req_cnt - rb, v.exp_reqs);
      chk($sformatf("v%0d done+error together", id), both_cnt - bb, 0);
      chk($sformatf("v%0d wb hold/idle violations", id), viol_cnt - vb, 0);
      chk($sformatf("v%0d busy/cyc after", id), {busy, cyc}, 0);
      n_act = trace.size() - tb0;
      chk($sformatf("v%0d trace length", id), n_act, exp_q.size());
      mism = 0; bad_i = -1; got_b = '0; want_b = '0;
      for (int i = 0; i < exp_q.size() && i < n_act; i++) begin
         if (trace[tb0 + i] !== exp_q[i]) begin
            if (mism == 0) begin bad_i = i; got_b = trace[tb0 + i]; want_b = exp_q[i]; end
            mism++;
         end
      end
      chk($sformatf("v%0d trace entries wrong (first idx %0d got %h want %h)", id, bad_i, got_b, want_b),
          mism, 0);
   endtask

   initial begin
      int rb;
      tbl[0] = '{1'b0, 11'h123, -1,    0,    -1,    1'b0, 1'b1, 16};
      tbl[1] = '{1'b1, 11'h7FF, -1,    0,    -1,    1'b0, 1'b1, 16};
      tbl[2] = '{1'b0, 11'h456, 'hC9,  5,    -1,    1'b0, 1'b1, 16};
      tbl[3] = '{1'b1, 11'h001, -1,    0,    'hCB,  1'b0, 1'b0, 0};
      tbl[4] = '{1'b0, 11'h0AA, 'h74,  1000, -1,    1'b1, 1'b0, 0};
      tbl[5] = '{1'b1, 11'h555, 'hCB,  2,    -1,    1'b1, 1'b1, 16};
      tbl[6] = '{1'b0, 11'h2C3, -1,    0,    'hC9,  1'b1, 1'b0, 16};

      repeat (3) @(negedge clk);
      chk("reset cyc/stb/we", {cyc, stb, we}, 0);
      chk("reset adr", adr, 0);
      chk("reset data_o", data_o, 0);
      chk("reset req/busy/done/error", {data_req, busy, done, error}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

      // Reset in the middle of the PROG payload, then a clean rerun.
      cfg_busy_op = -1; cfg_busy_n = 0; cfg_fail_op = -1; cfg_delay = 1'b0;
      @(negedge clk);
      rb = req_cnt;
      start = 1'b1; erase = 1'b0; page_addr = 11'h321;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5000 && (req_cnt - rb) < 7; i++) @(negedge clk);
      chk("mid-PROG reached byte 7", req_cnt - rb, 7);
      rst = 1'b1;
      @(negedge clk);
      chk("mid reset cyc/stb/we", {cyc, stb, we}, 0);
      chk("mid reset adr", adr, 0);
      chk("mid reset data_o", data_o, 0);
      chk("mid reset req/busy/done/error", {data_req, busy, done, error}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_vec(7, tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
